i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  Receives an I2S stream (sclk, lrclk, sdin) on the system clk and deserialises it into
//  16-bit left/right sample pairs. It is the receive end of the i2s transmitter that feeds
//  the sound DAC. It is used as an on-chip loopback checker for the sn76489 -> i2s path,
//  and it can take an external ADC on PMOD13. The serial inputs are asynchronous to clk.
//  clk must be at least 4x the sclk frequency.
// PARAMETERS
//  WIDTH        16  bits per channel word, MSB first; bits beyond WIDTH in a half-frame are ignored
//  SYNC_STAGES  2   flip-flop synchroniser depth on i_sclk, i_lrclk and i_sdin (minimum 2)
// PORTS
//  clk          in   1      system clock (100 MHz domain)
//  reset        in   1      synchronous, active-high reset
//  i_sclk       in   1      I2S bit clock, async
//  i_lrclk      in   1      I2S word select, async; 0 = left, 1 = right
//  i_sdin       in   1      I2S serial data, async
//  o_left       out  WIDTH  last complete left sample (two's complement, held)
//  o_right      out  WIDTH  last complete right sample (held)
//  o_valid      out  1      1-clk pulse when o_left/o_right update as a pair
//  o_err        out  1      1-clk pulse: lrclk changed before WIDTH bits captured
//  o_locked     out  1      high after first good frame; low after reset or o_err
// BEHAVIOUR
//  - Sync: all three inputs pass through SYNC_STAGES flops with equal delay, so the
//    relative alignment of sclk, lrclk and sdin is preserved.
//    rise = sclk_s & ~sclk_d; all sampling happens on rise cycles only.
//  - On each rise, sample lrclk_s and sdin_s. A word-select edge (ws != ws_prev) marks
//    the start of a channel. Per I2S, the MSB comes on the NEXT rise after the edge.
//  - FSM states:
//    SEEK   : wait for a 1->0 ws edge (start of left) -> SKIP_L
//    SKIP_L : next rise -> capture MSB, bitcnt=1, go LEFT
//    LEFT   : each rise shifts sdin in, bitcnt++. At bitcnt==WIDTH, hold shift_l and
//             ignore further bits. At a 0->1 ws edge: if bitcnt==WIDTH -> SKIP_R,
//             else -> error.
//    SKIP_R / RIGHT : same as SKIP_L / LEFT for the right channel. Right word completes
//             at bitcnt==WIDTH; the following 1->0 ws edge -> SKIP_L.
//  - Output update: on the clk after the right word's WIDTH-th bit is shifted in,
//    o_left <= shift_l, o_right <= shift_r, o_valid=1 for 1 clk, o_locked <= 1.
//    Latency is 1 clk from the capturing rise cycle.
//  - Error: a ws edge with bitcnt<WIDTH in LEFT/RIGHT, or a ws edge in SKIP_x, pulses
//    o_err for 1 clk, clears o_locked and discards the partial frame. The outputs keep
//    their old values. Next state: SEEK. If the edge was 1->0, go straight to SKIP_L
//    (resync in the same frame).
//  - A frame that starts on the right channel (first edge is 0->1) is ignored until
//    the next 1->0 edge.
//  - Continuous sclk with no ws edges: the FSM stays in its current state and no
//    pulses are generated.
//  - Reset (any cycle, including mid-word): state=SEEK, bitcnt=0, shift regs=0,
//    sync flops=0, o_left=o_right=0, o_valid=o_err=o_locked=0.
//  - o_valid and o_err are never high in the same cycle. The sclk/ws sync is free-running
//    and does not depend on o_valid being consumed (no backpressure).
// TESTING
//  1. sclk=clk/8, 32 sclk/frame; send L=16'h8001, R=16'h7FFE -> one o_valid,
//     o_left=8001, o_right=7FFE, o_locked=1.
//  2. 64 sclk/frame (32-bit slots), L=16'hA5A5 then 16 junk 1s, R=16'h1234
//     -> o_left=A5A5, o_right=1234; extra bits ignored.
//  3. ws toggles after 10 left bits -> o_err pulse, o_locked=0, o_left/o_right unchanged;
//     the next full frame gives o_valid.
//  4. Stream starts mid-right channel -> no o_valid until the first full L+R frame
//     after a 1->0 ws edge.
//  5. Reset asserted for 1 clk mid-left-word -> all outputs 0; the next complete
//     frame is decoded correctly.
//  6. Loopback with the i2s transmitter at i2s clock, ramp of 256 samples
//     -> o_right sequence matches, zero o_err.

Source files
------------

// File: rtl/i2s_rx_if.sv
// I2S receiver bus: async serial inputs in, deserialised sample pair and status out.
interface i2s_rx_if #(
  parameter int unsigned WIDTH = 16
);

  logic             i_sclk;
  logic             i_lrclk;
  logic             i_sdin;
  logic [WIDTH-1:0] o_left;
  logic [WIDTH-1:0] o_right;
  logic             o_valid;
  logic             o_err;
  logic             o_locked;

  // Serial source side: drives the I2S lines and observes the decoded samples.
  modport master (
    output i_sclk,
    output i_lrclk,
    output i_sdin,
    input  o_left,
    input  o_right,
    input  o_valid,
    input  o_err,
    input  o_locked
  );

  // Receiver side.
  modport slave (
    input  i_sclk,
    input  i_lrclk,
    input  i_sdin,
    output o_left,
    output o_right,
    output o_valid,
    output o_err,
    output o_locked
  );

endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: synchronises sclk/lrclk/sdin into clk and deserialises MSB-first
// left/right words into a held sample pair with valid/error/lock status.
module i2s_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    reset,
  i2s_rx_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    ST_SEEK,
    ST_SKIP_L,
    ST_LEFT,
    ST_SKIP_R,
    ST_RIGHT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ws_sync_q;
  logic [SYNC_STAGES-1:0] sdin_sync_q;
  logic                   sclk_prev_q;
  logic                   ws_prev_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [WIDTH-1:0]       shift_l_q;
  logic [WIDTH-1:0]       shift_r_q;
  logic [WIDTH-1:0]       left_q;
  logic [WIDTH-1:0]       right_q;
  logic                   valid_q;
  logic                   err_q;
  logic                   locked_q;

  logic                   sclk_s;
  logic                   ws_s;
  logic                   sdin_s;
  logic                   rise;
  logic                   ws_edge;
  logic                   word_full;
  logic                   word_lands;
  logic                   word_done;
  logic [CNT_W-1:0]       bitcnt_d;
  logic [WIDTH-1:0]       shift_l_d;
  logic [WIDTH-1:0]       shift_r_d;
  logic [WIDTH-1:0]       msb_d;

  // Equal-depth synchronisers keep sclk, lrclk and sdin aligned to each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sdin_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], bus.i_lrclk};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], bus.i_sdin};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s       = ws_sync_q[SYNC_STAGES-1];
  assign sdin_s     = sdin_sync_q[SYNC_STAGES-1];
  assign rise       = sclk_s & ~sclk_prev_q;
  assign ws_edge    = ws_s ^ ws_prev_q;

  // The bit sampled on a word-select edge rise is still the LSB of the word
  // that is ending, so completion is judged after that bit is taken in.
  assign word_full  = (bitcnt_q == CNT_FULL);
  assign word_lands = (bitcnt_q == CNT_LAST);
  assign word_done  = word_full | word_lands;
  assign bitcnt_d   = bitcnt_q + CNT_ONE;
  assign shift_l_d  = {shift_l_q[WIDTH-2:0], sdin_s};
  assign shift_r_d  = {shift_r_q[WIDTH-2:0], sdin_s};
  assign msb_d      = {{(WIDTH-1){1'b0}}, sdin_s};

  // Frame FSM: all decisions are taken on sclk rise cycles; pulses last one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SEEK;
      ws_prev_q <= 1'b0;
      bitcnt_q  <= '0;
      shift_l_q <= '0;
      shift_r_q <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rise) begin
        ws_prev_q <= ws_s;
        case (state_q)
          ST_SEEK: begin
            if (ws_edge && !ws_s) begin
              state_q <= ST_SKIP_L;
            end
          end
          ST_SKIP_L: begin
            if (ws_edge) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= ws_s ? ST_SEEK : ST_SKIP_L;
            end else begin
              shift_l_q <= msb_d;
              bitcnt_q  <= CNT_ONE;
              state_q   <= ST_LEFT;
            end
          end
          ST_LEFT: begin
            if (!word_full) begin
              shift_l_q <= shift_l_d;
              bitcnt_q  <= bitcnt_d;
            end
            if (ws_edge) begin
              bitcnt_q <= '0;
              if (word_done) begin
                state_q <= ST_SKIP_R;
              end else begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
                state_q  <= ws_s ? ST_SEEK : ST_SKIP_L;
              end
            end
          end
          ST_SKIP_R: begin
            if (ws_edge) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= ws_s ? ST_SEEK : ST_SKIP_L;
            end else begin
              shift_r_q <= msb_d;
              bitcnt_q  <= CNT_ONE;
              state_q   <= ST_RIGHT;
            end
          end
          ST_RIGHT: begin
            if (!word_full) begin
              shift_r_q <= shift_r_d;
              bitcnt_q  <= bitcnt_d;
            end
            if (word_lands) begin
              left_q   <= shift_l_q;
              right_q  <= shift_r_d;
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
            end
            if (ws_edge) begin
              bitcnt_q <= '0;
              state_q  <= ws_s ? ST_SEEK : ST_SKIP_L;
              if (!word_done) begin
                err_q    <= 1'b1;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= ST_SEEK;
            bitcnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_left   = left_q;
  assign bus.o_right  = right_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_err    = err_q;
  assign bus.o_locked = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds I2S bit streams, predicts the decoded event sequence
// from word-select runs, and compares it with what the receiver reports.
module tb_i2s_rx;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned HALF  = 4;

  logic        clk;
  logic        reset;
  int          n_checks = 0;
  int          n_errors = 0;

  bit          ws_q[$];
  bit          d_q[$];
  bit          em_ws[$];
  bit          em_d[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  i2s_rx_if #(.WIDTH(WIDTH)) bus ();

  i2s_rx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every pulse from the receiver; lock must track the pulse kind.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_valid) begin
        got_q.push_back({1'b0, bus.o_left, bus.o_right});
        check("locked_on_valid", 64'(bus.o_locked), 64'(1));
        check("valid_err_excl", 64'(bus.o_err), 64'(0));
      end
      if (bus.o_err) begin
        got_q.push_back({1'b1, bus.o_left, bus.o_right});
        check("locked_on_err", 64'(bus.o_locked), 64'(0));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_left"},   64'(bus.o_left),   64'(0));
    check({tag, "_right"},  64'(bus.o_right),  64'(0));
    check({tag, "_valid"},  64'(bus.o_valid),  64'(0));
    check({tag, "_err"},    64'(bus.o_err),    64'(0));
    check({tag, "_locked"}, 64'(bus.o_locked), 64'(0));
  endtask

  // One channel slot: ws held for len bit periods, word MSB first then junk.
  task automatic add_slot(input bit ch, input logic [WIDTH-1:0] w, input int len, input bit junk);
    logic [WIDTH-1:0] word;
    word = w;
    for (int i = 0; i < len; i++) begin
      ws_q.push_back(ch);
      if (i < int'(WIDTH)) d_q.push_back(word[int'(WIDTH) - 1 - i]);
      else                 d_q.push_back(junk);
    end
  endtask

  task automatic add_frame(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input int slot);
    add_slot(1'b0, l, slot, 1'b1);
    add_slot(1'b1, r, slot, 1'b1);
  endtask

  // Data lags word select by one bit period; one trailing period flushes the last LSB.
  task automatic build();
    int n;
    n = ws_q.size();
    em_ws.delete();
    em_d.delete();
    for (int k = 0; k <= n; k++) begin
      em_ws.push_back(k < n ? ws_q[k] : ws_q[n-1]);
      em_d.push_back(k == 0 ? 1'b0 : d_q[k-1]);
    end
  endtask

  // Reference: split the stream into word-select runs; each run after an edge
  // carries one word starting one period after the edge, and its LSB may land
  // on the next edge. A left run followed by a full right run is a sample pair.
  task automatic model(input int a, input int b, inout logic [31:0] last);
    int               e[$];
    bit               prev;
    bit               synced;
    logic [WIDTH-1:0] lw;
    prev   = 1'b0;
    synced = 1'b0;
    lw     = '0;
    for (int k = a; k < b; k++) begin
      if (em_ws[k] != prev) e.push_back(k);
      prev = em_ws[k];
    end
    for (int j = 0; j < e.size(); j++) begin
      int               st;
      int               len;
      int               avail;
      bit               ended;
      bit               ch;
      bit               complete;
      logic [WIDTH-1:0] w;
      st       = e[j];
      ended    = (j + 1 < e.size());
      len      = ended ? e[j+1] - st : b - st;
      avail    = ended ? len : len - 1;
      ch       = em_ws[st];
      complete = (len > 1) && (avail >= int'(WIDTH));
      w        = '0;
      for (int i = 0; i < int'(WIDTH) && i < avail; i++) w = {w[WIDTH-2:0], em_d[st+1+i]};
      if (!ch) begin
        if (complete) begin
          synced = 1'b1;
          lw     = w;
        end else begin
          synced = 1'b0;
          if (ended) exp_q.push_back({1'b1, last});
        end
      end else if (synced) begin
        if (complete) begin
          last = {lw, w};
          exp_q.push_back({1'b0, last});
        end else if (ended) begin
          exp_q.push_back({1'b1, last});
        end
        synced = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = 1'b0;
    bus.i_sdin  = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");
  endtask

  // Drive the stream: lines change with sclk low, receiver samples on sclk rise.
  task automatic emit(input int rst_idx);
    for (int k = 0; k < em_ws.size(); k++) begin
      bus.i_sclk  = 1'b0;
      bus.i_lrclk = em_ws[k];
      bus.i_sdin  = em_d[k];
      if (k == rst_idx) reset = 1'b1;
      for (int c = 0; c < int'(HALF); c++) begin
        @(posedge clk);
        #1;
        if (c == 0 && k == rst_idx) begin
          reset = 1'b0;
          check_reset_state("midword");
        end
      end
      bus.i_sclk = 1'b1;
      repeat (HALF) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_seg(input string name, input int rst_idx);
    logic [31:0] last;
    int          n;
    do_reset();
    last = '0;
    build();
    n = em_ws.size();
    if (rst_idx >= 0) begin
      model(0, rst_idx, last);
      last = '0;
      model(rst_idx, n, last);
    end else begin
      model(0, n, last);
    end
    emit(rst_idx);
    repeat (4 * HALF) @(posedge clk);
    #1;
    check({name, "_ev_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_ev%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    ws_q.delete();
    d_q.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int s;
    reset       = 1'b1;
    bus.i_sclk  = 1'b0;
    bus.i_lrclk = 1'b0;
    bus.i_sdin  = 1'b0;

    // Basic 16-bit slots; a short right lead-in provides the 1->0 start edge.
    add_slot(1'b1, 16'h0000, 4, 1'b0);
    add_frame(16'h8001, 16'h7FFE, 16);
    run_seg("basic", -1);
    check("basic_left",   64'(bus.o_left),   64'(16'h8001));
    check("basic_right",  64'(bus.o_right),  64'(16'h7FFE));
    check("basic_locked", 64'(bus.o_locked), 64'(1));

    // 32-bit slots with trailing junk ones that must be ignored.
    add_slot(1'b1, 16'h0000, 3, 1'b0);
    add_frame(16'hA5A5, 16'h1234, 32);
    run_seg("wide", -1);
    check("wide_left",  64'(bus.o_left),  64'(16'hA5A5));
    check("wide_right", 64'(bus.o_right), 64'(16'h1234));

    // Left word cut after 10 bits, then recovery on the next full frame.
    add_slot(1'b1, 16'h0000, 2, 1'b0);
    add_frame(16'h1111, 16'h2222, 16);
    add_slot(1'b0, 16'h3333, 10, 1'b0);
    add_slot(1'b1, 16'h4444, 16, 1'b0);
    add_frame(16'h5555, 16'h6666, 16);
    run_seg("short", -1);
    check("short_left",   64'(bus.o_left),   64'(16'h5555));
    check("short_locked", 64'(bus.o_locked), 64'(1));

    // Stream entering mid-right word.
    add_slot(1'b1, 16'hBEEF, 9, 1'b0);
    add_frame(16'h0F0F, 16'hF0F0, 18);
    run_seg("midright", -1);
    check("midright_right", 64'(bus.o_right), 64'(16'hF0F0));

    // Reset pulse in the middle of a left word.
    add_slot(1'b1, 16'h0000, 2, 1'b0);
    add_frame(16'hCAFE, 16'hBABE, 16);
    s = ws_q.size();
    add_frame(16'hDEAD, 16'hFACE, 16);
    add_frame(16'h1357, 16'h2468, 16);
    run_seg("rst", s + 6);
    check("rst_left",  64'(bus.o_left),  64'(16'h1357));
    check("rst_right", 64'(bus.o_right), 64'(16'h2468));

    // Random words, slot lengths and occasional truncated slots.
    for (int seg = 0; seg < 3; seg++) begin
      add_slot(1'b1, 16'(($urandom)), int'($urandom_range(1, 10)), 1'b0);
      for (int f = 0; f < 10; f++) begin
        for (int c = 0; c < 2; c++) begin
          int len;
          if ($urandom_range(0, 5) == 0) len = int'($urandom_range(2, 15));
          else                           len = int'($urandom_range(16, 24));
          add_slot(c[0], 16'($urandom), len, 1'($urandom_range(0, 1)));
        end
      end
      run_seg($sformatf("rand%0d", seg), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
